// File: rtl/icache_mshr_fill.sv
// rtl/icache_mshr_fill.sv - single-entry icache miss handler: bus request, line fill, critical-word forward, tag write
module icache_mshr_fill #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_BYTES = 32,
    parameter int SETS       = 64,
    localparam int BEATS     = LINE_BYTES * 8 / DATA_W,
    localparam int BEAT_W    = $clog2(BEATS),
    localparam int OFF_W     = $clog2(LINE_BYTES),
    localparam int IDX_W     = $clog2(SETS),
    localparam int TAG_W     = ADDR_W - IDX_W - OFF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_valid,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              miss_way,
    output logic              miss_ready,
    output logic              stall,
    output logic              mshr_bus_req,
    output logic [ADDR_W-1:0] mshr_bus_addr,
    input  logic              bus_mshr_ack,
    input  logic              bus_rdata_valid,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rlast,
    output logic              linefill_en,
    output logic              linefill_way,
    output logic [IDX_W-1:0]  linefill_index,
    output logic [BEAT_W-1:0] linefill_beat,
    output logic [DATA_W-1:0] linefill_data,
    output logic              fwd_valid,
    output logic [DATA_W-1:0] fwd_data,
    output logic              tag_wr_en,
    output logic              tag_wr_way,
    output logic [IDX_W-1:0]  tag_wr_index,
    output logic [TAG_W-1:0]  tag_wr_tag,
    output logic              fill_err
);

    // Byte-within-word bits select nothing here; the word index starts above them.
    localparam int WB_W = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_FILL  = 2'd2,
        S_TAGWR = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W-OFF_W-1:0]   line_q;
    logic                      way_q;
    logic [BEAT_W-1:0]         crit_q;
    logic [BEAT_W-1:0]         cnt_q;
    logic                      beat_fire;
    logic                      last_beat;
    logic                      unused_lsbs;

    assign unused_lsbs = ^miss_addr[WB_W-1:0];
    assign beat_fire   = (state_q == S_FILL) && bus_rdata_valid;
    assign last_beat   = (cnt_q == BEAT_W'(BEATS - 1));

    // State register; reset aborts any fill in progress immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: an early rlast drops the line and skips the tag write.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (miss_valid)   state_d = S_REQ;
            S_REQ:   if (bus_mshr_ack) state_d = S_FILL;
            S_FILL: begin
                if (bus_rdata_valid) begin
                    if (last_beat)      state_d = S_TAGWR;
                    else if (bus_rlast) state_d = S_IDLE;
                end
            end
            S_TAGWR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from state plus the live refill beat.
    always_comb begin
        miss_ready   = 1'b0;
        stall        = 1'b1;
        mshr_bus_req = 1'b0;
        linefill_en  = 1'b0;
        fwd_valid    = 1'b0;
        tag_wr_en    = 1'b0;
        fill_err     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                miss_ready = 1'b1;
                stall      = 1'b0;
            end
            S_REQ:   mshr_bus_req = 1'b1;
            S_FILL: begin
                linefill_en = beat_fire;
                fwd_valid   = beat_fire && (cnt_q == crit_q);
                fill_err    = beat_fire && bus_rlast && !last_beat;
            end
            S_TAGWR: tag_wr_en = 1'b1;
            default: ;
        endcase
    end

    // Miss capture: line address, victim way and the critical word index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
            way_q  <= 1'b0;
            crit_q <= '0;
        end else if (state_q == S_IDLE && miss_valid) begin
            line_q <= miss_addr[ADDR_W-1:OFF_W];
            way_q  <= miss_way;
            crit_q <= miss_addr[OFF_W-1:WB_W];
        end
    end

    // Beat counter: cleared on bus accept, advances per valid beat, never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == S_REQ && bus_mshr_ack) begin
            cnt_q <= '0;
        end else if (beat_fire) begin
            if (last_beat || bus_rlast) cnt_q <= '0;
            else                        cnt_q <= cnt_q + 1'b1;
        end
    end

    assign mshr_bus_addr  = {line_q, {OFF_W{1'b0}}};
    assign linefill_way   = way_q;
    assign linefill_index = line_q[IDX_W-1:0];
    assign linefill_beat  = cnt_q;
    assign linefill_data  = bus_rdata;
    assign fwd_data       = bus_rdata;
    assign tag_wr_way     = way_q;
    assign tag_wr_index   = line_q[IDX_W-1:0];
    assign tag_wr_tag     = line_q[ADDR_W-OFF_W-1:IDX_W];

endmodule

// File: tb/tb_icache_mshr_fill.sv
// tb/tb_icache_mshr_fill.sv - randomized self-checking bench for icache_mshr_fill
module tb_icache_mshr_fill;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic        miss_way;
    logic        miss_ready;
    logic        stall;
    logic        mshr_bus_req;
    logic [31:0] mshr_bus_addr;
    logic        bus_mshr_ack;
    logic        bus_rdata_valid;
    logic [31:0] bus_rdata;
    logic        bus_rlast;
    logic        linefill_en;
    logic        linefill_way;
    logic [5:0]  linefill_index;
    logic [2:0]  linefill_beat;
    logic [31:0] linefill_data;
    logic        fwd_valid;
    logic [31:0] fwd_data;
    logic        tag_wr_en;
    logic        tag_wr_way;
    logic [5:0]  tag_wr_index;
    logic [20:0] tag_wr_tag;
    logic        fill_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    icache_mshr_fill dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .miss_valid      (miss_valid),
        .miss_addr       (miss_addr),
        .miss_way        (miss_way),
        .miss_ready      (miss_ready),
        .stall           (stall),
        .mshr_bus_req    (mshr_bus_req),
        .mshr_bus_addr   (mshr_bus_addr),
        .bus_mshr_ack    (bus_mshr_ack),
        .bus_rdata_valid (bus_rdata_valid),
        .bus_rdata       (bus_rdata),
        .bus_rlast       (bus_rlast),
        .linefill_en     (linefill_en),
        .linefill_way    (linefill_way),
        .linefill_index  (linefill_index),
        .linefill_beat   (linefill_beat),
        .linefill_data   (linefill_data),
        .fwd_valid       (fwd_valid),
        .fwd_data        (fwd_data),
        .tag_wr_en       (tag_wr_en),
        .tag_wr_way      (tag_wr_way),
        .tag_wr_index    (tag_wr_index),
        .tag_wr_tag      (tag_wr_tag),
        .fill_err        (fill_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, miss_ready, 1);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_req"}, mshr_bus_req, 0);
        check({tag, "_lfen"}, linefill_en, 0);
        check({tag, "_fwd"}, fwd_valid, 0);
        check({tag, "_tagwr"}, tag_wr_en, 0);
        check({tag, "_err"}, fill_err, 0);
    endtask

    // One miss, end to end. err_beat<0 means a full line; abort_beat<0 means no reset.
    task automatic run_miss(input logic [31:0] addr, input logic way, input int ack_dly,
                            input int gap_min, input int gap_max, input int err_beat,
                            input int abort_beat, input bit seq_data, input bit busy_miss);
        logic [31:0] exp_ba;
        logic [5:0]  exp_idx;
        logic [20:0] exp_tag;
        int          crit;
        int          last;
        int          gaps;
        logic [31:0] d;
        exp_ba  = addr & 32'hFFFF_FFE0;
        exp_idx = 6'((addr / 32) % 64);
        exp_tag = 21'(addr / 2048);
        crit    = int'((addr / 4) % 8);
        last    = (err_beat >= 0) ? err_beat : 7;

        @(negedge clk);
        miss_valid = 1'b1; miss_addr = addr; miss_way = way;
        #1;
        check("cap_ready", miss_ready, 1);
        check("cap_stall", stall, 0);

        for (int i = 0; i <= ack_dly; i++) begin
            @(negedge clk);
            miss_valid      = busy_miss; miss_addr = $urandom; miss_way = 1'($urandom);
            bus_mshr_ack    = (i == ack_dly);
            bus_rdata_valid = 1'($urandom);
            bus_rdata       = $urandom;
            #1;
            check("req_req", mshr_bus_req, 1);
            check("req_addr", mshr_bus_addr, exp_ba);
            check("req_stall", stall, 1);
            check("req_ready", miss_ready, 0);
            check("req_lfen", linefill_en, 0);
            check("req_fwd", fwd_valid, 0);
        end

        for (int k = 0; k <= last; k++) begin
            gaps = int'($urandom_range(gap_max, gap_min));
            for (int g = 0; g < gaps; g++) begin
                @(negedge clk);
                bus_mshr_ack = 1'b0; bus_rdata_valid = 1'b0; bus_rlast = 1'b0;
                bus_rdata = $urandom; miss_addr = $urandom;
                #1;
                check("gap_lfen", linefill_en, 0);
                check("gap_fwd", fwd_valid, 0);
                check("gap_stall", stall, 1);
                check("gap_req", mshr_bus_req, 0);
            end
            @(negedge clk);
            d = seq_data ? 32'hA0 + 32'(k) : $urandom;
            bus_mshr_ack = 1'b0; bus_rdata_valid = 1'b1; bus_rdata = d;
            bus_rlast = (k == last); miss_addr = $urandom;
            #1;
            check("beat_lfen", linefill_en, 1);
            check("beat_num", linefill_beat, k);
            check("beat_idx", linefill_index, exp_idx);
            check("beat_way", linefill_way, way);
            check("beat_data", linefill_data, d);
            check("beat_fwd", fwd_valid, (k == crit));
            if (k == crit) check("fwd_data", fwd_data, d);
            check("beat_err", fill_err, (err_beat >= 0 && k == err_beat));
            check("beat_tagwr", tag_wr_en, 0);
            if (k == abort_beat) begin
                @(negedge clk);
                rst_n = 1'b0; bus_rdata_valid = 1'b0; bus_rlast = 1'b0; miss_valid = 1'b0;
                #1;
                check_idle_outputs("abort");
                check("abort_addr", mshr_bus_addr, 0);
                check("abort_beat", linefill_beat, 0);
                check("abort_tidx", tag_wr_index, 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end

        @(negedge clk);
        bus_rdata_valid = 1'($urandom); bus_rlast = 1'b0; bus_rdata = $urandom;
        if (err_beat >= 0) begin
            miss_valid = 1'b0;
            #1;
            check_idle_outputs("err_idle");
        end else begin
            miss_valid = busy_miss;
            #1;
            check("tw_en", tag_wr_en, 1);
            check("tw_way", tag_wr_way, way);
            check("tw_idx", tag_wr_index, exp_idx);
            check("tw_tag", tag_wr_tag, exp_tag);
            check("tw_stall", stall, 1);
            check("tw_lfen", linefill_en, 0);
            @(negedge clk);
            miss_valid = 1'b0; bus_rdata_valid = 1'($urandom);
            #1;
            check_idle_outputs("post_idle");
        end
        @(negedge clk);
        bus_rdata_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; miss_valid = 1'b0; miss_addr = '0; miss_way = 1'b0;
        bus_mshr_ack = 1'b0; bus_rdata_valid = 1'b0; bus_rdata = '0; bus_rlast = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_idle_outputs("reset_rel");
        check("reset_addr", mshr_bus_addr, 0);

        run_miss(32'h0000_1234, 1'b1, 0, 0, 0, -1, -1, 1'b1, 1'b0);
        run_miss(32'h0000_5678, 1'b0, 5, 0, 0, -1, -1, 1'b0, 1'b0);
        run_miss(32'h00AB_CD0C, 1'b1, 1, 2, 2, -1, -1, 1'b0, 1'b0);
        run_miss(32'h1234_5670, 1'b0, 0, 0, 1, 3, -1, 1'b0, 1'b1);
        run_miss(32'h0000_9ABC, 1'b1, 2, 0, 1, -1, 4, 1'b0, 1'b1);
        run_miss(32'h0000_1234, 1'b1, 0, 0, 0, -1, -1, 1'b1, 1'b0);

        for (int n = 0; n < 25; n++) begin
            int eb;
            eb = ($urandom_range(3, 0) == 0) ? int'($urandom_range(6, 0)) : -1;
            run_miss($urandom, 1'($urandom), int'($urandom_range(4, 0)), 0,
                     int'($urandom_range(3, 0)), eb, -1, 1'b0, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
